// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter - packed-BCD up/down counter with time-multiplexed digit scan.
// Optional LEADING_ZERO_BLANK_EN: blank digits above the most-significant non-zero digit.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          bcd_q, bcd_d;

  logic [3:0]          nib;
  logic                ripple;
  logic [IW-1:0]       msd;

  // Counter: clr beats load beats inc; ripple carries/borrows through the digits.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    nib     = 4'd0;
    ripple  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        nib = load_val[4*i +: 4];
        count_d[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
      end
    end else if (inc) begin
      ripple = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        nib = count_q[4*i +: 4];
        if (ripple) begin
          if (up) begin
            if (nib == 4'd9) begin
              count_d[4*i +: 4] = 4'd0;
            end else begin
              count_d[4*i +: 4] = nib + 4'd1;
              ripple = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              count_d[4*i +: 4] = 4'd9;
            end else begin
              count_d[4*i +: 4] = nib - 4'd1;
              ripple = 1'b0;
            end
          end
        end
      end
      carry_d = ripple;
    end
  end

  // Scan: an/bcd are registered from the index and count as they stand this cycle.
  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd0) msd = IW'(i);
    end

    an_d  = '1;
    bcd_d = 4'hF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        an_d[i] = 1'b0;
        bcd_d   = count_q[4*i +: 4];
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q > msd) bcd_d = 4'hF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      bcd_q   <= 4'hF;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign bcd   = bcd_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - vector table, corner sequences and random run against a decimal model.
module tb_bcd_scan_counter;
  localparam int ND   = 4;
  localparam int SDIV = 4;
  localparam int MODV = 10000;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, inc = 1'b0, up = 1'b0, load = 1'b0;
  logic [4*ND-1:0] load_val = '0;
  logic [4*ND-1:0] count;
  logic carry;
  logic [3:0] bcd;
  logic [ND-1:0] an;

  int checks = 0;
  int errors = 0;
  int mv = 0;
  int edges = 0;

  bcd_scan_counter #(.DIGITS(ND), .SCAN_DIV(SDIV)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .up(up), .load(load),
    .load_val(load_val), .count(count), .carry(carry), .bcd(bcd), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic c; logic l; logic [15:0] lv; logic i; logic u;
    logic [15:0] ecount; logic ecarry;
  } vec_t;

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int r = 0;
    int d;
    for (int k = 0; k < ND; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 0;
      r = r + d * pow10(k);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [15:0] lv, input logic i, input logic u);
    int old, idx, ecar;
    logic [3:0] ebcd;
    logic [3:0] ean;
    clr = c; load = l; load_val = lv; inc = i; up = u;
    @(posedge clk);
    old = mv;
    edges++;
    idx = ((edges - 1) / SDIV) % ND;
    ean = ~(4'b0001 << idx);
    ebcd = 4'((old / pow10(idx)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && old < pow10(idx)) ebcd = 4'hF;
`endif
    ecar = 0;
    if (c) mv = 0;
    else if (l) mv = from_load(lv);
    else if (i && u) begin
      if (old == MODV - 1) ecar = 1;
      mv = (old + 1) % MODV;
    end else if (i) begin
      if (old == 0) ecar = 1;
      mv = (old + MODV - 1) % MODV;
    end
    #1;
    check("count", 32'(count), 32'(to_bcd(mv)));
    check("carry", 32'(carry), 32'(ecar));
    check("an", 32'(an), 32'(ean));
    check("bcd", 32'(bcd), 32'(ebcd));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_carry"}, 32'(carry), 32'h0);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_bcd"}, 32'(bcd), 32'hF);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mv = 0;
    edges = 0;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b0, 1'b1, 16'h0999, 1'b0, 1'b0, 16'h0999, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h9999, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h12AF, 1'b0, 1'b0, 16'h1200, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 16'h0009, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h9999, 1'b1, 1'b1, 16'h9999, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9998, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0099, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'hFA42, 1'b1, 1'b1, 16'h0042, 1'b0});

    // Reset state and first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("first_an", 32'(an), 32'hE);
    check("first_bcd", 32'(bcd), 32'h0);

    foreach (vecs[n]) begin
      step(vecs[n].c, vecs[n].l, vecs[n].lv, vecs[n].i, vecs[n].u);
      check($sformatf("vec%0d_count", n), 32'(count), 32'(vecs[n].ecount));
      check($sformatf("vec%0d_carry", n), 32'(carry), 32'(vecs[n].ecarry));
    end

    // Full scan rotation over 0042 with the index re-aligned by a reset.
    rst_n = 1'b0;
    #1;
    release_reset();
    step(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
    for (int n = 0; n < 4 * SDIV * 2; n++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Random stimulus, with asynchronous resets dropped into inc bursts.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [15:0] lv;
      r = $urandom_range(0, 99);
      lv = ($urandom_range(0, 2) == 0) ? ((($urandom & 1) != 0) ? 16'h9999 : 16'h0000) : 16'($urandom);
      step(r < 3, (r >= 3) && (r < 9), lv, ($urandom_range(0, 3) != 0), 1'($urandom));
      if (n % 150 == 149) begin
        inc = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        release_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
